// File: rtl/cipher_char_sequencer.sv
// cipher_char_sequencer: routes letters through a cipher core, bypasses other bytes, emits all in order via a FIFO.
// Define CHAR_SEQ_STATS_EN to add the letter_cnt/pass_cnt statistics outputs.
module cipher_char_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_char,
  output logic       cph_din_valid,
  output logic [7:0] cph_txt_in_char,
  input  logic [7:0] cph_txt_out_char,
  input  logic       cph_dout_ready,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_char,
  output logic       timeout_err
`ifdef CHAR_SEQ_STATS_EN
  ,
  output logic [15:0] letter_cnt,
  output logic [15:0] pass_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          terr_q, terr_d;
  logic          run_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          is_letter, push, pop, core_done;
  logic [7:0]    push_data;

  assign is_letter = (s_char >= 8'h41 && s_char <= 8'h5A) || (s_char >= 8'h61 && s_char <= 8'h7A);
  // run_q keeps s_ready low until the first edge after reset release
  assign s_ready = run_q && state_q == IDLE && cnt_q < CW'(FIFO_DEPTH);
  assign m_valid = cnt_q != '0;
  assign m_char = m_valid ? mem_q[rd_q] : 8'h00;
  assign pop = m_valid && m_ready;
  assign cph_din_valid = state_q == ISSUE;
  assign cph_txt_in_char = cur_q;
  assign timeout_err = terr_q;
  assign core_done = state_q == WAIT && cph_dout_ready;

  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    wait_d = wait_q;
    terr_d = terr_q;
    push = 1'b0;
    push_data = s_char;
    if (state_q == ISSUE) begin
      state_d = WAIT;
      wait_d = '0;
    end else if (state_q == WAIT) begin
      if (cph_dout_ready) begin
        push = 1'b1;
        push_data = cph_txt_out_char;
        state_d = IDLE;
      end else if (wait_q == WW'(TIMEOUT - 1)) begin
        push = 1'b1;
        push_data = cur_q;
        terr_d = 1'b1;
        state_d = IDLE;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end else if (s_valid && s_ready) begin
      push = !is_letter;
      cur_d = is_letter ? s_char : cur_q;
      state_d = is_letter ? ISSUE : IDLE;
    end
  end

  // FIFO space for a letter is reserved when it is accepted, so the WAIT push never overflows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q <= 8'h00;
      wait_q <= '0;
      terr_q <= 1'b0;
      run_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      wait_q <= wait_d;
      terr_q <= terr_d;
      run_q <= 1'b1;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

`ifdef CHAR_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_cnt <= 16'h0000;
      pass_cnt <= 16'h0000;
    end else begin
      letter_cnt <= letter_cnt + 16'(core_done && letter_cnt != 16'hFFFF);
      pass_cnt <= pass_cnt + 16'(push && !core_done && pass_cnt != 16'hFFFF);
    end
  end
`else
  logic unused_core_done;
  assign unused_core_done = core_done;
`endif
endmodule

// File: tb/tb_cipher_char_sequencer.sv
// tb_cipher_char_sequencer: directed and randomized checks against a queue-based reference model
// with a behavioural cipher core (shift cipher, key 8'h2B) driven from the stimulus process.
module tb_cipher_char_sequencer;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_char = 8'h00;
  logic m_ready = 1'b0;
  logic cph_dout_ready = 1'b0;
  logic [7:0] cph_txt_out_char = 8'h00;
  logic s_ready, cph_din_valid, m_valid, timeout_err;
  logic [7:0] cph_txt_in_char, m_char;
`ifdef CHAR_SEQ_STATS_EN
  logic [15:0] letter_cnt, pass_cnt;
`endif

  cipher_char_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_char(s_char),
    .cph_din_valid(cph_din_valid), .cph_txt_in_char(cph_txt_in_char),
    .cph_txt_out_char(cph_txt_out_char), .cph_dout_ready(cph_dout_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_char(m_char), .timeout_err(timeout_err)
`ifdef CHAR_SEQ_STATS_EN
    , .letter_cnt(letter_cnt), .pass_cnt(pass_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int mode = 0, dly = 1, cur_dly = 0, pend = 0, dv_cnt = 0, let_cnt = 0, tick_cnt = 0;
  bit accepted = 0, rnd_m = 0, terr_m = 0;
  logic [7:0] last_l = 8'h00;
  logic [7:0] exp_q[$], got_q[$], orig[$], ctext[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_let(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // mode 0 encrypts (shift by key mod 26), mode 1 decrypts, mode 2 is a constant-output stub
  function automatic logic [7:0] core_f(input logic [7:0] c);
    int sh;
    if (mode == 2) return 8'h3C;
    sh = (mode == 0) ? (43 % 26) : (26 - 43 % 26);
    if (c >= "A" && c <= "Z") return 8'(65 + (int'(c) - 65 + sh) % 26);
    if (c >= "a" && c <= "z") return 8'(97 + (int'(c) - 97 + sh) % 26);
    return c;
  endfunction

  task automatic tick();
    accepted = 0;
    if (s_valid && s_ready) begin
      accepted = 1;
      if (is_let(s_char)) begin
        let_cnt++;
        last_l = s_char;
        cur_dly = dly;
        if (dly >= 1 && dly <= TO) exp_q.push_back(core_f(s_char));
        else begin
          exp_q.push_back(s_char);
          terr_m = 1;
        end
      end else exp_q.push_back(s_char);
    end
    if (m_valid && m_ready) begin
      got_q.push_back(m_char);
      if (exp_q.size() == 0) chk("unexpected_pop", 32'(m_char), 32'hFFFF_FFFF);
      else chk("m_char_order", 32'(m_char), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
    tick_cnt++;
    if (cph_din_valid) begin
      dv_cnt++;
      chk("txt_in_char", 32'(cph_txt_in_char), 32'(last_l));
      pend = cur_dly;
      cph_dout_ready = 1'b0;
      cph_txt_out_char = core_f(cph_txt_in_char);
    end else if (pend > 0) begin
      pend--;
      cph_dout_ready = (pend == 0);
    end else cph_dout_ready = 1'b0;
    if (rnd_m) m_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_char = c;
    do begin
      tick();
      n++;
    end while (!accepted && n < 100);
    if (!accepted) chk("send_accept", 32'(accepted), 1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_m = 0;
    m_ready = 1'b1;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int t0, dv0, bad;
    logic [7:0] c;
    s_valid = 1'b1;
    s_char = "A";
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_din_valid", 32'(cph_din_valid), 0);
    chk("rst_txt_in", 32'(cph_txt_in_char), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_char", 32'(m_char), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    #1 chk("release_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    chk("post_release_s_ready", 32'(s_ready), 1);
    chk("post_release_m_valid", 32'(m_valid), 0);
    s_valid = 1'b0;

    s = " ,.1";
    mode = 0;
    got_q.delete();
    dv0 = dv_cnt;
    t0 = tick_cnt;
    for (int i = 0; i < 4; i++) send(s[i]);
    chk("burst_cycles", 32'(tick_cnt - t0), 4);
    drain();
    chk("burst_no_din_valid", 32'(dv_cnt - dv0), 0);
    for (int i = 0; i < 4; i++) chk("burst_char", 32'(got_q[i]), 32'(s[i]));

    mode = 2;
    dly = 1;
    dv0 = dv_cnt;
    s_valid = 1'b1;
    s_char = "a";
    tick();
    s_valid = 1'b0;
    chk("a_accepted", 32'(accepted), 1);
    chk("a_issue_dv", 32'(cph_din_valid), 1);
    chk("a_issue_txt", 32'(cph_txt_in_char), 32'h61);
    tick();
    chk("a_wait_dv", 32'(cph_din_valid), 0);
    chk("a_wait_m_valid", 32'(m_valid), 0);
    tick();
    chk("a_out_m_valid", 32'(m_valid), 1);
    chk("a_out_m_char", 32'(m_char), 32'h3C);
    drain();
    chk("a_dv_pulses", 32'(dv_cnt - dv0), 1);

    mode = 0;
    m_ready = 1'b0;
    s = "Hi!?";
    for (int i = 0; i < 3; i++) send(s[i]);
    chk("hi_s_ready_cnt3", 32'(s_ready), 1);
    chk("hi_m_valid", 32'(m_valid), 1);
    send(s[3]);
    chk("hi_s_ready_full", 32'(s_ready), 0);
    chk("hi_head", 32'(m_char), 32'(core_f("H")));
    drain();

    m_ready = 1'b0;
    dly = 0;
    send("Z");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_pending_m_valid", 32'(m_valid), 0);
      chk("to_pending_err", 32'(timeout_err), 0);
    end
    tick();
    chk("to_m_valid", 32'(m_valid), 1);
    chk("to_m_char", 32'(m_char), 32'h5A);
    chk("to_err", 32'(timeout_err), 1);
    drain();
    dly = 1;
    got_q.delete();
    send("b");
    drain();
    chk("b_char", 32'(got_q[0]), 32'(core_f("b")));
    chk("to_err_sticky", 32'(timeout_err), 1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: orig.push_back(8'h20);
        1: begin
          s = ",.!?0-";
          orig.push_back(s[$urandom_range(0, 5)]);
        end
        2: orig.push_back(8'(($urandom_range(0, 3) == 0) ? 8'h00 : 8'(8'h80 + $urandom_range(0, 127))));
        3: orig.push_back(8'(65 + $urandom_range(0, 25)));
        default: orig.push_back(8'(97 + $urandom_range(0, 25)));
      endcase
    end
    mode = 0;
    got_q.delete();
    rnd_m = 1;
    foreach (orig[i]) begin
      dly = $urandom_range(1, TO);
      if ($urandom_range(0, 3) == 0) tick();
      send(orig[i]);
    end
    drain();
    ctext = got_q;
    chk("rt_cipher_len", 32'(ctext.size()), 32'(orig.size()));
    mode = 1;
    got_q.delete();
    rnd_m = 1;
    foreach (ctext[i]) begin
      dly = $urandom_range(1, TO);
      send(ctext[i]);
    end
    drain();
    chk("rt_plain_len", 32'(got_q.size()), 32'(orig.size()));
    bad = 0;
    foreach (orig[i]) if (i < got_q.size() && got_q[i] !== orig[i]) bad++;
    chk("rt_mismatches", 32'(bad), 0);

    mode = 0;
    rnd_m = 1;
    for (int i = 0; i < 60; i++) begin
      dly = $urandom_range(0, 5);
      c = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'(97 + $urandom_range(0, 25));
      send(c);
    end
    drain();
    chk("rand_timeout_err", 32'(timeout_err), 32'(terr_m));
    chk("rand_din_pulses", 32'(dv_cnt), 32'(let_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cipher_char_sequencer.md
Name: cipher_char_sequencer

Overview:
- Sits between a byte-stream source (file reader, UART RX) and aes_sbox_stream_cipher; a sink consumes its output.
- Takes characters over a valid/ready handshake and issues only alphabetic characters to the cipher core.
- Captures the core's result when the core signals dout_ready; non-letters bypass the core.
- Presents all characters in original order through an output FIFO with valid/ready, for encryption or decryption alike.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- TIMEOUT, 4, WAIT cycles allowed for cph_dout_ready before the timeout path is taken; >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream character valid.
- s_ready  out  1  block accepts s_char this cycle.
- s_char  in  8  upstream character.
- cph_din_valid  out  1  to core din_valid.
- cph_txt_in_char  out  8  to core txt_in_char.
- cph_txt_out_char  in  8  from core txt_out_char.
- cph_dout_ready  in  1  from core dout_ready.
- m_valid  out  1  output character valid (FIFO non-empty).
- m_ready  in  1  downstream accepts m_char.
- m_char  out  8  FIFO head character (first-word fall-through).
- timeout_err  out  1  sticky; set when a letter times out.

Behaviour:
- Letter classification: 8'h41..8'h5A or 8'h61..8'h7A. Every other value, including 8'h00 and >=8'h80, is a non-letter.
- FSM states: IDLE, ISSUE, WAIT.
- s_ready = (state==IDLE) && (fifo_count < FIFO_DEPTH). It is combinational from registered state. It ignores a same-cycle pop.
- IDLE, handshake with a non-letter: s_char is written to the FIFO at that edge. State stays IDLE. Throughput is 1 char/cycle.
- IDLE, handshake with a letter: s_char goes into cur_char. Next state is ISSUE.
- ISSUE, exactly one cycle: cph_din_valid=1 and cph_txt_in_char=cur_char. Next state is WAIT with wait_cnt=0.
- cph_din_valid is 0 in every other state. cph_txt_in_char holds cur_char at all times.
- WAIT with cph_dout_ready=1: cph_txt_out_char is written to the FIFO. Next state is IDLE.
- WAIT with cph_dout_ready=0: wait_cnt increments. When wait_cnt==TIMEOUT-1, cur_char (unencrypted) is written to the FIFO, timeout_err is set, and next state is IDLE.
- cph_dout_ready outside WAIT is ignored.
- Nominal letter latency: the core asserts dout_ready in the first WAIT cycle. Accept edge to FIFO write is 2 cycles; accept to m_valid is 3 cycles when the FIFO was empty. Letter throughput is 1 char per 3 cycles.
- FIFO space for a letter is reserved at acceptance. Only one character is in flight, so the WAIT write can never overflow.
- FIFO pop occurs when m_valid && m_ready.
- A push and a pop on the same edge leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
- Ordering is strictly preserved; no character is dropped or duplicated.
- timeout_err clears only on reset.
- Reset values (asynchronous, immediate): state=IDLE, s_ready=0 while rst_n=0, cph_din_valid=0, cph_txt_in_char=0, m_valid=0, m_char=0, timeout_err=0. FIFO is empty.
- Reset mid-operation: any in-flight letter and all FIFO contents are discarded.

Optional Feature:
- Macro: CHAR_SEQ_STATS_EN.
- Defined: adds outputs letter_cnt[15:0] and pass_cnt[15:0], both reset to 0.
  - letter_cnt increments on each WAIT completion via dout_ready.
  - pass_cnt increments on each non-letter FIFO write and each timeout write.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset with s_valid=1, m_ready=1, s_char="A": all outputs 0 during reset. s_ready rises the cycle after rst_n deasserts.
- Non-letter burst " ,.1" with m_ready=1 and a stub core: cph_din_valid never asserts. m_char sequence is 8'h20,8'h2C,8'h2E,8'h31, one per cycle.
- Letter "a" with the stub returning 8'h3C and dout_ready one cycle after din_valid: cph_din_valid high for exactly one cycle with cph_txt_in_char=8'h61. m_char=8'h3C, 3 cycles after accept.
- "Hi!" with m_ready=0 and FIFO_DEPTH=4: three entries, then s_ready=1 with count 3. A fourth character fills the FIFO and s_ready=0. Raising m_ready drains the FIFO in order.
- Stub core never asserts dout_ready, input "Z": after TIMEOUT=4 WAIT cycles, m_char=8'h5A and timeout_err=1 (sticky). A following "b" completes normally and timeout_err stays 1.
- Full round trip: the real cipher with key 8'h2B encrypts a paragraph, then the ciphertext is fed back through a second pass. The output equals the original text byte for byte, with punctuation positions unchanged.
